// File: rtl/spi_ram.sv
// ---------------------------------------------------------------------------
// spi_ram
//   Command-driven byte RAM sitting behind an SPI slave. Each rx_valid cycle
//   carries one 10-bit word: din[9:8] selects the command, din[7:0] is the
//   payload.
//     00 : load write address      01 : write payload to mem[wr_addr]
//     10 : load read address       11 : read mem[rd_addr] into dout
//   A read raises tx_valid for TX_HOLD cycles so the slave can shift dout out.
//   Any other command during that window cuts the window short; another read
//   restarts it with tx_valid kept high.
//
// Ports
//   clk      in   1   clock, rising edge
//   rst_n    in   1   synchronous active-low reset
//   din      in  10   command word {cmd[1:0], payload[7:0]}
//   rx_valid in   1   din qualifier, one command per high cycle
//   dout     out  8   read data (holds after tx_valid falls)
//   tx_valid out  1   dout valid for shifting out
//
// Build option
//   SPI_RAM_ADDR_AUTOINC_EN : when defined, wr_addr advances after every
//   command 01 and rd_addr after every command 11, wrapping at 2^ADDR_SIZE.
// ---------------------------------------------------------------------------
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

`ifdef SPI_RAM_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam int CNT_W = (TX_HOLD < 1) ? 1 : $clog2(TX_HOLD + 1);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  logic [7:0]           mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [CNT_W-1:0]     hold_q, hold_d;

  logic                 wr_in_range;
  logic                 rd_in_range;
  logic [7:0]           rd_word;

  // Addresses beyond the populated depth are legal to hold but never touch
  // storage: writes are dropped and reads return zero.
  assign wr_in_range = (int'(wr_addr_q) < MEM_DEPTH);
  assign rd_in_range = (int'(rd_addr_q) < MEM_DEPTH);
  assign rd_word     = rd_in_range ? mem[rd_addr_q] : 8'h00;

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    hold_d     = hold_q;

    // Hold window countdown; tx_valid drops on the edge the count hits 0,
    // giving exactly TX_HOLD high cycles after the read edge.
    if (tx_valid_q) begin
      if (hold_q <= CNT_W'(1)) begin
        tx_valid_d = 1'b0;
        hold_d     = '0;
      end else begin
        hold_d = hold_q - 1'b1;
      end
    end

    // A new command overrides the countdown above.
    if (rx_valid) begin
      case (din[9:8])
        CMD_WR_ADDR: begin
          wr_addr_d  = din[ADDR_SIZE-1:0];
          tx_valid_d = 1'b0;
          hold_d     = '0;
        end
        CMD_WR_DATA: begin
          // Increment happens even when the write itself is dropped.
          if (AUTOINC) wr_addr_d = wr_addr_q + 1'b1;
          tx_valid_d = 1'b0;
          hold_d     = '0;
        end
        CMD_RD_ADDR: begin
          rd_addr_d  = din[ADDR_SIZE-1:0];
          tx_valid_d = 1'b0;
          hold_d     = '0;
        end
        default: begin
          dout_d     = rd_word;
          tx_valid_d = 1'b1;
          hold_d     = CNT_W'(TX_HOLD);
          if (AUTOINC) rd_addr_d = rd_addr_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= 8'h00;
      tx_valid_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      hold_q     <= hold_d;
    end
  end

  // Storage is never cleared; only the write path is gated by reset so a
  // command presented during reset cannot land in memory.
  always_ff @(posedge clk) begin
    if (rst_n && rx_valid && (din[9:8] == CMD_WR_DATA) && wr_in_range) begin
      mem[wr_addr_q] <= din[7:0];
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, number of 8-bit words stored.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, width of the stored write and read address registers.
REQ-003 The block SHALL have parameter TX_HOLD, default 9, number of cycles tx_valid stays high per read.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset; it is synchronous and active-low.
REQ-006 The block SHALL have port din, input, 10, the received word from the upstream SPI slave; din[9:8] is the command and din[7:0] the payload.
REQ-007 The block SHALL have port rx_valid, input, 1, din qualifier; it is sampled once per high cycle, and each high cycle is one command.
REQ-008 The block SHALL have port dout, output, 8, the read data returned to the SPI slave for serialisation.
REQ-009 The block SHALL have port tx_valid, output, 1, high while dout is valid for shifting out.

Function
REQ-010 The block SHALL act only on clock edges where rx_valid=1 and rst_n=1; din SHALL be ignored otherwise.
REQ-011 For command 00, the block SHALL load wr_addr with din[ADDR_SIZE-1:0].
REQ-012 For command 01, the block SHALL write din[7:0] to mem[wr_addr].
REQ-013 For command 10, the block SHALL load rd_addr with din[ADDR_SIZE-1:0].
REQ-014 For command 11, the block SHALL register mem[rd_addr] into dout at that edge, ignore din[7:0], and set tx_valid=1 from the next cycle.
REQ-015 Read latency SHALL be 1 cycle: dout and tx_valid are both registered and change together on the same edge.
REQ-016 On a command 11, the block SHALL load a hold counter with TX_HOLD.
REQ-017 The hold counter SHALL decrement each cycle while tx_valid=1.
REQ-018 tx_valid SHALL deassert on the edge where the hold counter reaches 0, so it is high for exactly TX_HOLD cycles.
REQ-019 dout SHALL hold its value after tx_valid falls, until the next command 11 or reset.
REQ-020 A command 00, 01 or 10 arriving while tx_valid=1 SHALL clear tx_valid and the hold counter at that edge; dout SHALL be unchanged.
REQ-021 A command 11 arriving while tx_valid=1 SHALL reload dout and the hold counter, with tx_valid staying continuously high.
REQ-022 A write to an address >= MEM_DEPTH SHALL be dropped with no state change.
REQ-023 A read from an address >= MEM_DEPTH SHALL return dout=8'h00, with tx_valid behaving normally.
REQ-024 A command 11 issued the cycle after a command 01 to the same address SHALL return the newly written data.
REQ-025 Memory SHALL be single-write, single-read per cycle; one command per cycle means there is no port conflict.

Reset
REQ-026 With rst_n=0 at a clock edge, dout SHALL become 8'h00 and tx_valid SHALL become 0.
REQ-027 With rst_n=0 at a clock edge, wr_addr, rd_addr and the hold counter SHALL become 0.
REQ-028 Memory contents SHALL NOT be reset and are undefined until written.
REQ-029 A reset asserted mid-hold SHALL drop tx_valid at that edge.
REQ-030 An rx_valid high in the same cycle as reset SHALL be discarded.

Configuration
REQ-031 Macro SPI_RAM_ADDR_AUTOINC_EN defined: wr_addr SHALL increment by 1 after each command 01.
REQ-032 Macro SPI_RAM_ADDR_AUTOINC_EN defined: rd_addr SHALL increment by 1 after each command 11.
REQ-033 Macro SPI_RAM_ADDR_AUTOINC_EN defined: both increments SHALL wrap modulo 2^ADDR_SIZE, including after a dropped out-of-range access.
REQ-034 Macro SPI_RAM_ADDR_AUTOINC_EN undefined: wr_addr and rd_addr SHALL change only on commands 00 and 10.

Verification
REQ-035 Write 0x3C then 0x01A5, then 0x23C then 0x300 -> dout=0xA5 one cycle after the 0x300 rx_valid, with tx_valid high for exactly 9 cycles.
REQ-036 Issue a command 11, then a 0x055 three cycles into the hold -> tx_valid falls at the 0x055 edge, dout is unchanged, and mem is untouched.
REQ-037 With MEM_DEPTH=200, write 0x0C8 then 0x1FF, then read 0x2C8 then 0x300 -> dout=0x00, tx_valid pulses for 9 cycles, and no stored word changes.
REQ-038 Assert rst_n=0 during the hold on cycle 4 -> tx_valid=0 and dout=0x00 at that edge; a following 0x300 reads address 0.
REQ-039 With SPI_RAM_ADDR_AUTOINC_EN, write 0x0FF, 0x111, 0x122 -> mem[0xFF]=0x11 and mem[0x00]=0x22; a read from 0x2FF followed by two 0x300 commands returns 0x11 then 0x22.
REQ-040 Without SPI_RAM_ADDR_AUTOINC_EN, run the same sequence -> mem[0xFF]=0x22, and both reads return 0x22.
